// File: rtl/timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_ctrl : bus-mapped timer controller that extends a narrow timer count
//              with an overflow epoch and raises a compare-match interrupt.
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
module timer_ctrl #(
  parameter int NS_CNT_WIDTH = 2,
  parameter int EPOCH_WIDTH  = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NS_CNT_WIDTH-1:0] ns_cnt_i,
  input  logic                    overflow_i,
  output logic                    to_clear_timer_o,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [1:0]              addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  output logic                    ack_o,
  output logic                    irq_o
);

  localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADDR_STATUS = 2'd1;
  localparam logic [1:0] C_ADDR_TIME   = 2'd2;
  localparam logic [1:0] C_ADDR_CMP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [EPOCH_WIDTH-1:0]  r_epoch;
  logic                    r_irq_en;
  logic                    r_match;
  logic                    r_ovf;
  logic                    r_ge_d;
  logic [31:0]             r_cmp;
  logic [31:0]             r_rdata;
  logic                    r_ack;
  logic                    r_irq;

  logic                    w_wr;
  logic                    w_rd;
  logic                    w_clr_wr;
  logic                    w_status_wr;
  logic                    w_ovf_inc;
  logic                    w_ge;
  logic                    w_match_set;
  logic [31:0]             w_time;
  logic [31:0]             w_rdata;

  assign w_wr        = req_i && we_i;
  assign w_rd        = req_i && !we_i;
  assign w_clr_wr    = w_wr && (addr_i == C_ADDR_CTRL) && wdata_i[1];
  assign w_status_wr = w_wr && (addr_i == C_ADDR_STATUS);
  // A software clear in the same cycle overrides the overflow increment.
  assign w_ovf_inc   = (r_state == S_IDLE) && overflow_i && !w_clr_wr;
  assign w_time      = {r_epoch, ns_cnt_i};
  assign w_ge        = (w_time >= r_cmp);
  // Match is edge-triggered so a W1C can clear it while TIME stays above CMP.
  assign w_match_set = w_ge && !r_ge_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    to_clear_timer_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (overflow_i || w_clr_wr) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        to_clear_timer_o = 1'b1;
        w_next           = S_WAIT;
      end
      S_WAIT: begin
        if (!overflow_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epoch  <= '0;
      r_irq_en <= 1'b0;
      r_match  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ge_d   <= 1'b0;
      r_cmp    <= 32'hFFFF_FFFF;
      r_irq    <= 1'b0;
    end else begin
      r_ge_d <= w_ge;
      r_irq  <= r_match && r_irq_en;
      if (w_clr_wr) begin
        r_epoch <= '0;
      end else if (w_ovf_inc) begin
        r_epoch <= r_epoch + 1'b1;
      end
      if (w_wr && (addr_i == C_ADDR_CTRL)) begin
        r_irq_en <= wdata_i[0];
      end
      if (w_wr && (addr_i == C_ADDR_CMP)) begin
        r_cmp <= wdata_i;
      end
      r_match <= w_match_set || (r_match && !(w_status_wr && wdata_i[0]));
      r_ovf   <= w_ovf_inc   || (r_ovf   && !(w_status_wr && wdata_i[1]));
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (addr_i)
      C_ADDR_CTRL:   w_rdata = {31'd0, r_irq_en};
      C_ADDR_STATUS: w_rdata = {30'd0, r_ovf, r_match};
      C_ADDR_TIME:   w_rdata = w_time;
      C_ADDR_CMP:    w_rdata = r_cmp;
      default:       w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= req_i;
      r_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign ack_o   = r_ack;
  assign rdata_o = r_rdata;
  assign irq_o   = r_irq;

endmodule
`default_nettype wire
